// File: rtl/reg_file_legv8_pkg.sv
// Shared LEGv8 datapath constants: register and select widths, zero-register index, flag bit positions.
package reg_file_legv8_pkg;

  localparam int LEGV8_DATA_W  = 64;
  localparam int LEGV8_ADDR_W  = 5;
  localparam int LEGV8_XZR_IDX = 31;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/reg_file_legv8_if.sv
// Register file access bus: two read selects and data, one write port, and the status-flag capture port.
interface reg_file_legv8_if
  import reg_file_legv8_pkg::*;
#(
  parameter int DATA_W = LEGV8_DATA_W,
  parameter int ADDR_W = LEGV8_ADDR_W
);
  logic [ADDR_W-1:0] SA;
  logic [ADDR_W-1:0] SB;
  logic [ADDR_W-1:0] DA;
  logic              W;
  logic [DATA_W-1:0] D;
  logic              SL;
  logic [3:0]        status_in;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        flags;

  modport master (
    output SA, SB, DA, W, D, SL, status_in,
    input  A, B, flags
  );

  modport slave (
    input  SA, SB, DA, W, D, SL, status_in,
    output A, B, flags
  );
endinterface

// File: rtl/reg_file_legv8_read_port.sv
// Purpose: one combinational read port; the all-ones select is XZR and reads zero.
// Latency: zero cycles, select to data.
// Backpressure: none, the port is always ready.
module reg_read_port #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                        sel,
  input  logic [(2**ADDR_W)-2:0][DATA_W-1:0]       regs,
  output logic [DATA_W-1:0]                        dat
);

  localparam int NUM_STORED = (2**ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] XZR = '1;

  logic [DATA_W-1:0] sel_dat;

  // Compare-and-select keeps the XZR index from ever addressing past the stored array.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_STORED; i++) begin
      if (sel == ADDR_W'(i)) begin
        sel_dat = regs[i];
      end
    end
  end

  assign dat = (sel == XZR) ? '0 : sel_dat;

endmodule

// File: rtl/reg_file_legv8.sv
// Purpose: LEGv8 register file X0-X30 (XZR reads zero) plus registered {V,C,N,Z} flags.
// Latency: reads combinational; writes and flag capture visible the cycle after the edge.
// Backpressure: none, a write or flag load is accepted every cycle.
module reg_file_legv8
  import reg_file_legv8_pkg::*;
#(
  parameter int DATA_W = LEGV8_DATA_W,
  parameter int ADDR_W = LEGV8_ADDR_W
) (
  input  logic             clock,
  input  logic             reset,
  reg_file_legv8_if.slave  bus
);

  localparam int NUM_STORED = (2**ADDR_W) - 1;

  logic [NUM_STORED-1:0][DATA_W-1:0] regs;
  logic [3:0]                        flags_q;

  // The XZR select never matches a stored index, so writes to it fall away.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs    <= '0;
      flags_q <= '0;
    end else begin
      for (int i = 0; i < NUM_STORED; i++) begin
        if (bus.W && (bus.DA == ADDR_W'(i))) begin
          regs[i] <= bus.D;
        end
      end
      if (bus.SL) begin
        flags_q <= bus.status_in;
      end
    end
  end

  assign bus.flags = flags_q;

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
    .sel  (bus.SA),
    .regs (regs),
    .dat  (bus.A)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
    .sel  (bus.SB),
    .regs (regs),
    .dat  (bus.B)
  );

endmodule

// File: tb/tb_reg_file_legv8.sv
// Bench for reg_file_legv8: directed vectors, a vector table, and random traffic against an array model.
module tb_reg_file_legv8;

  logic clock;
  logic reset;

  reg_file_legv8_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  reg_file_legv8 #(.DATA_W(64), .ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [63:0] model_regs [32];
  logic [3:0]  model_flags;

  typedef struct {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic        w;
    logic [63:0] d;
    logic        sl;
    logic [3:0]  st;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
                       input logic w, input logic [63:0] d, input logic sl, input logic [3:0] st);
    bus.SA = sa; bus.SB = sb; bus.DA = da; bus.W = w; bus.D = d; bus.SL = sl; bus.status_in = st;
  endtask

  // Advance one clock edge and let combinational reads settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference behaviour of one rising edge, applied to the model.
  task automatic model_edge(input logic rst, input logic [4:0] da, input logic w,
                            input logic [63:0] d, input logic sl, input logic [3:0] st);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      model_flags = '0;
    end else begin
      if (w && da != 5'd31) model_regs[da] = d;
      if (sl) model_flags = st;
    end
  endtask

  initial begin
    logic [4:0]  r_sa, r_sb, r_da;
    logic        r_w, r_sl, r_rst;
    logic [63:0] r_d;
    logic [3:0]  r_st;

    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_flags = '0;

    vecs[0] = '{5'd1, 5'd2,  5'd1, 1'b1, 64'd7,  1'b0, 4'b0000, 64'd0, 64'd0, 4'b0000};
    vecs[1] = '{5'd1, 5'd2,  5'd2, 1'b1, 64'd9,  1'b0, 4'b0000, 64'd7, 64'd0, 4'b0000};
    vecs[2] = '{5'd1, 5'd2,  5'd0, 1'b0, 64'd0,  1'b0, 4'b0000, 64'd7, 64'd9, 4'b0000};
    vecs[3] = '{5'd2, 5'd2,  5'd0, 1'b0, 64'd0,  1'b1, 4'b1010, 64'd9, 64'd9, 4'b0000};
    vecs[4] = '{5'd5, 5'd31, 5'd0, 1'b0, 64'd0,  1'b0, 4'b0101, 64'hDEAD_BEEF_0123_4567, 64'd0, 4'b1010};
    vecs[5] = '{5'd0, 5'd0,  5'd0, 1'b0, 64'd0,  1'b0, 4'b0101, 64'd0, 64'd0, 4'b1010};
    vecs[6] = '{5'd4, 5'd4,  5'd4, 1'b1, 64'd5,  1'b1, 4'b0011, 64'd0, 64'd0, 4'b1010};
    vecs[7] = '{5'd4, 5'd4,  5'd0, 1'b0, 64'd0,  1'b0, 4'b0000, 64'd5, 64'd5, 4'b0011};

    // Reset and sweep every select.
    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    for (int s = 0; s < 32; s++) begin
      drive(5'(s), 5'(s), 5'd0, 1'b0, 64'd0, 1'b0, 4'b0000);
      #1;
      chk($sformatf("reset_sweep_A[%0d]", s), bus.A, 64'd0);
      chk($sformatf("reset_sweep_B[%0d]", s), bus.B, 64'd0);
    end
    chk("reset_flags", 64'(bus.flags), 64'd0);

    // Write X5 while reading it: old value now, new value next cycle.
    drive(5'd5, 5'd0, 5'd5, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 4'b0000);
    #1;
    chk("x5_same_cycle", bus.A, 64'd0);
    tick();
    model_edge(1'b0, 5'd5, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 4'b0000);
    bus.W = 1'b0;
    #1;
    chk("x5_next_cycle", bus.A, 64'hDEAD_BEEF_0123_4567);

    // Write to XZR is discarded.
    drive(5'd0, 5'd0, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b0000);
    tick();
    model_edge(1'b0, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b0000);
    drive(5'd31, 5'd31, 5'd0, 1'b0, 64'd0, 1'b0, 4'b0000);
    #1;
    chk("xzr_read_A", bus.A, 64'd0);
    chk("xzr_read_B", bus.B, 64'd0);
    for (int s = 0; s < 31; s++) begin
      bus.SA = 5'(s);
      #1;
      chk($sformatf("xzr_unchanged[%0d]", s), bus.A, model_regs[s]);
    end

    // Table of single-cycle vectors; outputs checked before each edge.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].sa, vecs[i].sb, vecs[i].da, vecs[i].w, vecs[i].d, vecs[i].sl, vecs[i].st);
      #1;
      chk($sformatf("vec%0d_A", i), bus.A, vecs[i].exp_a);
      chk($sformatf("vec%0d_B", i), bus.B, vecs[i].exp_b);
      chk($sformatf("vec%0d_flags", i), 64'(bus.flags), 64'(vecs[i].exp_flags));
      tick();
      model_edge(1'b0, vecs[i].da, vecs[i].w, vecs[i].d, vecs[i].sl, vecs[i].st);
    end

    // Reset beats a simultaneous write and flag load, and wipes earlier contents.
    reset = 1'b1;
    drive(5'd3, 5'd5, 5'd3, 1'b1, 64'd42, 1'b1, 4'b1111);
    tick();
    model_edge(1'b1, 5'd3, 1'b1, 64'd42, 1'b1, 4'b1111);
    reset = 1'b0;
    drive(5'd3, 5'd5, 5'd0, 1'b0, 64'd0, 1'b0, 4'b0000);
    #1;
    chk("rst_prio_x3", bus.A, 64'd0);
    chk("rst_wipe_x5", bus.B, 64'd0);
    chk("rst_prio_flags", 64'(bus.flags), 64'd0);

    // Random traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      r_sa  = 5'($urandom_range(0, 31));
      r_sb  = ($urandom_range(0, 7) == 0) ? r_sa : 5'($urandom_range(0, 31));
      r_da  = 5'($urandom_range(0, 31));
      r_w   = 1'($urandom_range(0, 1));
      r_d   = {$urandom, $urandom};
      r_sl  = 1'($urandom_range(0, 1));
      r_st  = 4'($urandom_range(0, 15));
      r_rst = ($urandom_range(0, 63) == 0);
      reset = r_rst;
      drive(r_sa, r_sb, r_da, r_w, r_d, r_sl, r_st);
      #1;
      chk($sformatf("rnd%0d_A", n), bus.A, model_regs[r_sa]);
      chk($sformatf("rnd%0d_B", n), bus.B, model_regs[r_sb]);
      chk($sformatf("rnd%0d_flags", n), 64'(bus.flags), 64'(model_flags));
      tick();
      model_edge(r_rst, r_da, r_w, r_d, r_sl, r_st);
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
